// File: rtl/znmi_multi_if.sv
// Request/control and status bundle for the multi-source NMI controller.
// The master side drives the Z80 strobes and requests; the slave side is the controller.
interface znmi_multi_if #(
  parameter int NSRC = 4
);
  logic            zpos;
  logic            int_start;
  logic            rfsh_n;
  logic [NSRC-1:0] set_nmi;
  logic [NSRC-1:0] src_en;
  logic            sync_mode;
  logic            clr_nmi;
  logic            in_nmi;
  logic            gen_nmi;
  logic [NSRC-1:0] nmi_cause;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] lost_nmi;

  modport master (
    output zpos, int_start, rfsh_n, set_nmi, src_en, sync_mode, clr_nmi,
    input  in_nmi, gen_nmi, nmi_cause, pending, lost_nmi
  );

  modport slave (
    input  zpos, int_start, rfsh_n, set_nmi, src_en, sync_mode, clr_nmi,
    output in_nmi, gen_nmi, nmi_cause, pending, lost_nmi
  );
endinterface

// File: rtl/znmi_multi.sv
// Multi-source NMI controller: falling-edge requests, lowest-index priority,
// fixed-length NMI_N pulse and refresh-counted exit from NMI mode.
module znmi_multi #(
  parameter int NSRC      = 4,
  parameter int PULSE_LEN = 16,
  parameter int CLR_RFSH  = 3
) (
  input  logic          fclk,
  input  logic          rst_n,
  znmi_multi_if.slave   bus
);
  localparam int              PW         = $clog2(PULSE_LEN + 1);
  localparam logic [PW-1:0]   PULSE_INIT = PW'(PULSE_LEN);
  localparam logic [3:0]      CLR_INIT   = 4'(CLR_RFSH);

  logic [NSRC-1:0] set_nmi_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] lost_q, lost_d;
  logic [NSRC-1:0] cause_q, cause_d;
  logic [NSRC-1:0] req, lowest, accept;
  logic            in_nmi_q, in_nmi_d;
  logic            clr_busy_q, clr_busy_d;
  logic [PW-1:0]   pulse_q, pulse_d;
  logic [3:0]      clr_cnt_q, clr_cnt_d;
  logic            strobe, fire, clr_done;

  assign req      = set_nmi_q & ~bus.set_nmi;
  // Two's-complement trick isolates the lowest set bit of the pending vector.
  assign lowest   = pending_q & (~pending_q + NSRC'(1));
  assign strobe   = bus.sync_mode ? bus.int_start : bus.zpos;
  assign fire     = (|pending_q) & ~in_nmi_q & ~clr_busy_q & strobe;
  assign accept   = fire ? lowest : '0;
  assign clr_done = clr_busy_q & (clr_cnt_q == 4'd0);

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    assign pending_d[gi] = ~bus.src_en[gi] ? 1'b0 :
                           req[gi]         ? 1'b1 :
                           accept[gi]      ? 1'b0 : pending_q[gi];
    assign lost_d[gi]    = (req[gi] & pending_q[gi] & bus.src_en[gi] & ~accept[gi]) ? 1'b1 :
                           bus.clr_nmi     ? 1'b0 : lost_q[gi];
  end

  always_comb begin
    in_nmi_d   = in_nmi_q;
    cause_d    = cause_q;
    clr_busy_d = clr_busy_q;
    clr_cnt_d  = clr_cnt_q;
    pulse_d    = (pulse_q != '0) ? pulse_q - PW'(1) : pulse_q;
    if (fire) begin
      in_nmi_d = 1'b1;
      cause_d  = lowest;
      pulse_d  = PULSE_INIT;
    end
    // fire and clr_done are exclusive since fire needs clr_busy low.
    if (bus.clr_nmi) begin
      clr_cnt_d  = CLR_INIT;
      clr_busy_d = 1'b1;
    end else if (clr_done) begin
      in_nmi_d   = 1'b0;
      cause_d    = '0;
      clr_busy_d = 1'b0;
    end else if (clr_busy_q & bus.zpos & ~bus.rfsh_n) begin
      clr_cnt_d  = clr_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      set_nmi_q  <= '0;
      pending_q  <= '0;
      lost_q     <= '0;
      cause_q    <= '0;
      in_nmi_q   <= 1'b0;
      clr_busy_q <= 1'b0;
      clr_cnt_q  <= 4'd0;
      pulse_q    <= '0;
    end else begin
      set_nmi_q  <= bus.set_nmi;
      pending_q  <= pending_d;
      lost_q     <= lost_d;
      cause_q    <= cause_d;
      in_nmi_q   <= in_nmi_d;
      clr_busy_q <= clr_busy_d;
      clr_cnt_q  <= clr_cnt_d;
      pulse_q    <= pulse_d;
    end
  end

  assign bus.in_nmi    = in_nmi_q;
  assign bus.gen_nmi   = (pulse_q != '0);
  assign bus.nmi_cause = cause_q;
  assign bus.pending   = pending_q;
  assign bus.lost_nmi  = lost_q;
endmodule
